mem_arbiter: RTL
================

# mem_arbiter

Shares the core's single memory port between instruction fetch and load/store. Accepts one request at a time from each side, arbitrates with data priority and a fetch anti-starvation bound, and runs a one-outstanding handshake on the memory bus. It also generates store byte masks, extracts and extends load data, and rejects misaligned or illegal accesses without any bus traffic. It sits between the fetch stage / execute stage and the memory bus, driven by the decoder's `mem_write`, `wb_src` and `ext_ctrl` outputs.

## Interface
- `STARVE_MAX`, default 4: maximum consecutive data grants issued while fetch is pending.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request; `if_addr` held stable until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_ack`  out  1  one-cycle response pulse.
- `if_rdata`  out  32  fetched word, valid with `if_ack`.
- `if_err`  out  1  misaligned fetch, valid with `if_ack`.
- `d_req`  in  1  data request; all `d_*` inputs held stable until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data, right-aligned.
- `d_ext`  in  3  funct3 of the load/store.
- `d_ack`  out  1  one-cycle response pulse.
- `d_rdata`  out  32  extended load data, valid with `d_ack`; 0 for stores.
- `d_err`  out  1  misaligned or illegal funct3, valid with `d_ack`.
- `m_req`  out  1  bus request; held, with the other `m_*` outputs stable, until `m_gnt`.
- `m_we`  out  1  bus write.
- `m_addr`  out  32  word address, bits [1:0] = 0.
- `m_wdata`  out  32  lane-replicated store data.
- `m_wmask`  out  4  byte-enable; 0 for reads.
- `m_gnt`  in  1  bus accepts the request this cycle.
- `m_rvalid`  in  1  response arrives, at least 1 cycle after `m_gnt`; also sent for writes.
- `m_rdata`  in  32  read word, valid with `m_rvalid`.

## Operation
- States and transitions:
  - IDLE: arbitrate; on a chosen request, go to ISSUE, or go to RESP with err=1 if the access is illegal.
  - ISSUE: `m_req`=1; go to WAIT on `m_gnt`.
  - WAIT: go to RESP on `m_rvalid`.
  - RESP: ack pulse; return to IDLE.
- Arbitration in IDLE:
  - Only one side requesting: that side wins.
  - Both requesting: data wins unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- `starve_cnt` (saturating):
  - Increments on a data grant while `if_req` is high.
  - Clears on a fetch grant, or in any IDLE cycle with `if_req` low.
- Legality:
  - Fetch: `if_addr[1:0]` must be 0.
  - Loads: `d_ext` ∈ {000, 001, 010, 100, 101}.
  - Stores: `d_ext` ∈ {000, 001, 010}.
  - Alignment: half needs `addr[0]`=0; word needs `addr[1:0]`=0.
- Store path:
  - SB: `m_wdata` = `{4{wdata[7:0]}}`, `m_wmask` = `0001 << addr[1:0]`.
  - SH: `m_wdata` = `{2{wdata[15:0]}}`, `m_wmask` = `0011 << {addr[1],1'b0}`.
  - SW: `m_wdata` = `wdata`, `m_wmask` = `1111`.
- Load path: select the byte/half at `addr[1:0]` from `m_rdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- The captured request (side, address, ext, we, wdata) is registered at the IDLE grant. Requester inputs are not re-sampled until the next IDLE.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, `starve_cnt` 0.
- Legal access with `m_gnt` in the ISSUE cycle and `m_rvalid` one cycle later:
  - req high in cycle 0, `m_req` in cycle 1, WAIT in cycle 2, ack in cycle 3.
  - Each extra stall cycle on `m_gnt` or `m_rvalid` adds one cycle.
- Illegal access: req high in cycle 0, ack with err=1 in cycle 1. `m_req` never rises.
- Back-to-back accesses: a req held in the RESP cycle is not a new request. It is arbitrated in the following IDLE cycle, giving a minimum of 4 cycles per bus access.
- Simultaneous `m_gnt` and `m_rvalid` in ISSUE: `m_rvalid` is ignored, since a response cannot precede its grant.
- Reset mid-transaction: the FSM returns to IDLE immediately and no ack is issued. The bus slave shares `rst_n`, so no stale `m_rvalid` follows.

## Structure
- Package `mem_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - funct3 constants (`EXT_B`, `EXT_H`, `EXT_W`, `EXT_BU`, `EXT_HU`).
  - Requester-select enum (`SEL_IF`, `SEL_D`).
- Sub-module `mem_align`, combinational: takes ext, addr[1:0], we, wdata and rdata. Produces wmask, lane wdata, extended rdata and an illegal flag. It is reused by any future cache.

## Test plan
- Single fetch at 0x100, bus returns 0x00000013 with no stalls → `if_ack` at cycle 3 with `if_rdata`=0x00000013, `if_err`=0.
- LB at 0x203, bus rdata 0x80FFFFFF → `d_rdata`=0xFFFFFF80. The same access as LBU → 0x00000080. `m_addr`=0x200 in both cases.
- SH at 0x302 with wdata 0x1234ABCD → `m_wdata`=0xABCDABCD, `m_wmask`=1100, `d_rdata`=0.
- LW at 0x401, or `d_ext`=011 → `d_ack`/`d_err` at cycle 1 and `m_req` stays 0.
- Both requesters held continuously with `STARVE_MAX`=4 → grant order D,D,D,D,IF,D,D,D,D,IF…
- Assert `rst_n` low during WAIT → outputs 0 asynchronously; after release, no ack and IDLE accepts a new fetch normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter and its alignment helper.
package mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_D  = 1'b1
  } sel_e;

  // funct3 encodings of loads/stores.
  localparam logic [2:0] EXT_B  = 3'b000;
  localparam logic [2:0] EXT_H  = 3'b001;
  localparam logic [2:0] EXT_W  = 3'b010;
  localparam logic [2:0] EXT_BU = 3'b100;
  localparam logic [2:0] EXT_HU = 3'b101;

endpackage

// File: rtl/mem_arbiter_align.sv
// Combinational byte-lane helper: store mask/lane replication, load extraction
// and extension, and legality of funct3/alignment.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  ext,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Pick the addressed byte and half-word out of the bus read word.
  always_comb begin
    rd_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Decode funct3 into lane controls; stores return no read data.
  always_comb begin
    wmask      = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    illegal    = 1'b0;
    if (we) begin
      case (ext)
        EXT_B: begin
          wmask      = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        EXT_H: begin
          illegal    = addr_lo[0];
          wmask      = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_lane = {2{wdata[15:0]}};
        end
        EXT_W: begin
          illegal    = |addr_lo;
          wmask      = 4'b1111;
          wdata_lane = wdata;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (ext)
        EXT_B:  rdata_ext = {{24{rd_byte[7]}}, rd_byte};
        EXT_BU: rdata_ext = {24'h0, rd_byte};
        EXT_H: begin
          illegal   = addr_lo[0];
          rdata_ext = {{16{rd_half[15]}}, rd_half};
        end
        EXT_HU: begin
          illegal   = addr_lo[0];
          rdata_ext = {16'h0, rd_half};
        end
        EXT_W: begin
          illegal   = |addr_lo;
          rdata_ext = rdata;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single memory port shared between instruction fetch and load/store, with
// data priority, a fetch anti-starvation bound and a one-outstanding bus.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ext,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_e      state_q, state_d;
  sel_e        sel_q, sel_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  ext_q, ext_d;
  logic        we_q, we_d;
  logic [CW-1:0] starve_q, starve_d;

  logic        if_ack_q, if_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_err_q, if_err_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wmask_q, m_wmask_d;

  logic        pick_if, pick_d;
  logic [31:0] live_addr;
  logic [2:0]  live_ext;
  logic        live_we;

  logic [2:0]  al_ext;
  logic [1:0]  al_addr_lo;
  logic        al_we;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_illegal;

  // Arbitration winner and its request fields; a fetch is checked as an aligned word load.
  always_comb begin
    pick_if   = if_req && (!d_req || (starve_q == STARVE_LIM));
    pick_d    = d_req && !pick_if;
    live_addr = pick_d ? d_addr : if_addr;
    live_ext  = pick_d ? d_ext : EXT_W;
    live_we   = pick_d && d_we;
  end

  // One alignment unit: checks the live request in IDLE, extracts load data otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      al_ext     = live_ext;
      al_addr_lo = live_addr[1:0];
      al_we      = live_we;
    end else begin
      al_ext     = ext_q;
      al_addr_lo = addr_lo_q;
      al_we      = we_q;
    end
  end

  mem_align u_align (
    .ext        (al_ext),
    .addr_lo    (al_addr_lo),
    .we         (al_we),
    .wdata      (d_wdata),
    .rdata      (m_rdata),
    .wmask      (al_wmask),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .illegal    (al_illegal)
  );

  // Next-state, starvation counter and registered output values.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_lo_d  = addr_lo_q;
    ext_d      = ext_q;
    we_d       = we_q;
    starve_d   = starve_q;
    if_ack_d   = 1'b0;
    if_rdata_d = '0;
    if_err_d   = 1'b0;
    d_ack_d    = 1'b0;
    d_rdata_d  = '0;
    d_err_d    = 1'b0;
    m_req_d    = 1'b0;
    m_we_d     = 1'b0;
    m_addr_d   = '0;
    m_wdata_d  = '0;
    m_wmask_d  = '0;

    case (state_q)
      IDLE: begin
        if (!if_req || pick_if) begin
          starve_d = '0;
        end else if (pick_d && (starve_q != STARVE_LIM)) begin
          starve_d = starve_q + CW'(1);
        end
        if (pick_if || pick_d) begin
          sel_d     = pick_d ? SEL_D : SEL_IF;
          addr_lo_d = live_addr[1:0];
          ext_d     = live_ext;
          we_d      = live_we;
          if (al_illegal) begin
            state_d  = RESP;
            if_ack_d = pick_if;
            if_err_d = pick_if;
            d_ack_d  = pick_d;
            d_err_d  = pick_d;
          end else begin
            state_d   = ISSUE;
            m_req_d   = 1'b1;
            m_we_d    = live_we;
            m_addr_d  = {live_addr[31:2], 2'b00};
            m_wdata_d = al_wdata;
            m_wmask_d = al_wmask;
          end
        end
      end
      ISSUE: begin
        // A response in the grant cycle cannot belong to this request, so m_rvalid is not looked at here.
        if (m_gnt) begin
          state_d = WAIT;
        end else begin
          m_req_d   = 1'b1;
          m_we_d    = m_we_q;
          m_addr_d  = m_addr_q;
          m_wdata_d = m_wdata_q;
          m_wmask_d = m_wmask_q;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          state_d = RESP;
          if (sel_q == SEL_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = al_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = al_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= SEL_IF;
      addr_lo_q  <= '0;
      ext_q      <= '0;
      we_q       <= 1'b0;
      starve_q   <= '0;
      if_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wmask_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_lo_q  <= addr_lo_d;
      ext_q      <= ext_d;
      we_q       <= we_d;
      starve_q   <= starve_d;
      if_ack_q   <= if_ack_d;
      if_rdata_q <= if_rdata_d;
      if_err_q   <= if_err_d;
      d_ack_q    <= d_ack_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wmask_q  <= m_wmask_d;
    end
  end

  assign if_ack   = if_ack_q;
  assign if_rdata = if_rdata_q;
  assign if_err   = if_err_q;
  assign d_ack    = d_ack_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wmask  = m_wmask_q;

endmodule
